// File: rtl/instr_mem_fetch.sv
// Instruction RAM with a pipelined, credit-controlled fetch port, a byte-enabled
// load port, a response FIFO, branch-redirect flush and fetch error flagging.
module instr_mem_fetch #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       DEPTH     = 1024,
   parameter int unsigned       READ_LAT  = 1,
   parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fetch_req_i,
   input  logic [ADDR_W-1:0]   fetch_addr_i,
   output logic                fetch_gnt_o,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_instr_o,
   output logic                rsp_err_o,
   input  logic                flush_i,
   input  logic                wr_en_i,
   input  logic [ADDR_W-1:0]   wr_addr_i,
   input  logic [DATA_W-1:0]   wr_data_i,
   input  logic [DATA_W/8-1:0] wr_be_i
);

   localparam int unsigned BW    = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BW);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned FD    = READ_LAT + 1;
   localparam int unsigned CNT_W = $clog2(FD + 1);
   localparam int unsigned PTR_W = $clog2(FD);

   localparam logic [ADDR_W:0]   Limit   = (ADDR_W + 1)'(DEPTH * BW);
   localparam logic [ADDR_W-1:0] OffMask = ADDR_W'(BW - 1);

   function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
      return (|(a & OffMask)) || ({1'b0, a} >= Limit);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(a >> OFF_W);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FD - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              wr_ok;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  f_idx;
   logic              f_err;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] f_data;

   logic              pop;
   logic              accept;
   logic [CNT_W-1:0]  outst_q, outst_d;

   logic              push_vld;
   logic [DATA_W-1:0] push_data;
   logic              push_err;

   logic [DATA_W-1:0] fifo_data_q [FD];
   logic              fifo_err_q  [FD];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  wr_slot;

   assign wr_ok  = wr_en_i && !addr_bad(wr_addr_i);
   assign wr_idx = addr_idx(wr_addr_i);
   assign f_idx  = addr_idx(fetch_addr_i);
   assign f_err  = addr_bad(fetch_addr_i);

   // Byte-enabled load port; memory contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int b = 0; b < BW; b++) begin
            if (wr_be_i[b]) mem_q[wr_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
         end
      end
   end

   // Write-first read: merge same-cycle write bytes into the fetched word.
   always_comb begin
      rd_word = mem_q[f_idx];
      if (wr_ok && (wr_idx == f_idx)) begin
         for (int b = 0; b < BW; b++) begin
            if (wr_be_i[b]) rd_word[8*b +: 8] = wr_data_i[8*b +: 8];
         end
      end
      f_data = f_err ? NOP_INSTR : rd_word;
   end

   // Credits cover pipe plus FIFO so the FIFO can never overflow.
   assign pop         = rsp_valid_o && rsp_ready_i;
   assign fetch_gnt_o = (outst_q < CNT_W'(FD)) || pop;
   assign accept      = fetch_req_i && fetch_gnt_o;

   // Outstanding-request counter; a flush keeps only this cycle's acceptance.
   always_comb begin
      outst_d = outst_q + CNT_W'(accept) - CNT_W'(pop);
      if (flush_i) outst_d = CNT_W'(accept);
   end

   // Outstanding counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) outst_q <= '0;
      else        outst_q <= outst_d;
   end

   generate
      if (READ_LAT == 2) begin : g_pipe
         logic              p_vld_q;
         logic [DATA_W-1:0] p_data_q;
         logic              p_err_q;

         // Extra RAM output stage; a flush kills the in-flight entry only.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               p_vld_q  <= 1'b0;
               p_data_q <= '0;
               p_err_q  <= 1'b0;
            end else begin
               p_vld_q <= accept;
               if (accept) begin
                  p_data_q <= f_data;
                  p_err_q  <= f_err;
               end
            end
         end

         assign push_vld  = p_vld_q && !flush_i;
         assign push_data = p_data_q;
         assign push_err  = p_err_q;
      end else begin : g_direct
         assign push_vld  = accept;
         assign push_data = f_data;
         assign push_err  = f_err;
      end
   endgenerate

   // FIFO pointer/count next state; flush empties it but keeps a same-cycle push.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      wr_slot  = wr_ptr_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_slot  = '0;
         wr_ptr_d = push_vld ? ptr_inc('0) : '0;
         cnt_d    = CNT_W'(push_vld);
      end else begin
         if (push_vld) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)      rd_ptr_d = ptr_inc(rd_ptr_q);
         cnt_d = cnt_q + CNT_W'(push_vld) - CNT_W'(pop);
      end
   end

   // FIFO storage and pointers; storage cleared so the idle head reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < FD; i++) begin
            fifo_data_q[i] <= '0;
            fifo_err_q[i]  <= 1'b0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         if (push_vld) begin
            fifo_data_q[wr_slot] <= push_data;
            fifo_err_q[wr_slot]  <= push_err;
         end
      end
   end

   assign rsp_valid_o = (cnt_q != '0);
   assign rsp_instr_o = fifo_data_q[rd_ptr_q];
   assign rsp_err_o   = fifo_err_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch (READ_LAT=1, 32-bit words, 1024 deep).
module tb_instr_mem_fetch;

   logic        clk;
   logic        rst_n;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_gnt;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic        rsp_err;
   logic        flush;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;

   int checks   = 0;
   int failures = 0;
   int ngrant;

   instr_mem_fetch #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .DEPTH    (1024),
      .READ_LAT (1),
      .NOP_INSTR(32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_req_i (fetch_req),
      .fetch_addr_i(fetch_addr),
      .fetch_gnt_o (fetch_gnt),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_instr_o (rsp_instr),
      .rsp_err_o   (rsp_err),
      .flush_i     (flush),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .wr_be_i     (wr_be)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_be   = be;
      cyc();
      wr_en   = 1'b0;
   endtask

   // Single fetch with ready high; leaves the bench at the negedge the response is visible.
   task automatic fetch1(input logic [31:0] a);
      rsp_ready  = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = a;
      cyc();
      fetch_req  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; rsp_ready = 1'b0; flush = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      repeat (2) cyc();
      chk("reset_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset_instr", rsp_instr, 32'd0);
      chk("reset_err",   {31'b0, rsp_err},   32'd0);
      rst_n = 1'b1;
      cyc();
      chk("reset_gnt",   {31'b0, fetch_gnt}, 32'd1);

      // Load two words and fetch them back-to-back.
      wr(32'h0, 32'h1111_1111, 4'hF);
      wr(32'h4, 32'h2222_2222, 4'hF);
      rsp_ready = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
      #1 chk("b2b_gnt0", {31'b0, fetch_gnt}, 32'd1);
      cyc();
      fetch_addr = 32'h4;
      #1 chk("b2b_gnt1", {31'b0, fetch_gnt}, 32'd1);
      chk("b2b_valid0", {31'b0, rsp_valid}, 32'd1);
      chk("b2b_data0", rsp_instr, 32'h1111_1111);
      cyc();
      fetch_req = 1'b0;
      chk("b2b_valid1", {31'b0, rsp_valid}, 32'd1);
      chk("b2b_data1", rsp_instr, 32'h2222_2222);
      cyc();
      chk("b2b_empty", {31'b0, rsp_valid}, 32'd0);

      // Byte enables.
      wr(32'h8, 32'hAABB_CCDD, 4'hF);
      wr(32'h8, 32'h0000_0099, 4'b0001);
      fetch1(32'h8);
      chk("be_data", rsp_instr, 32'hAABB_CC99);
      chk("be_err",  {31'b0, rsp_err}, 32'd0);
      cyc();

      // Back-pressure: only READ_LAT+1 = 2 requests granted.
      rsp_ready = 1'b0;
      ngrant = 0;
      for (int i = 0; i < 5; i++) begin
         fetch_req  = 1'b1;
         fetch_addr = (i % 3) * 4;
         #1 if (fetch_gnt) ngrant++;
         cyc();
      end
      #1 chk("bp_gnt_low", {31'b0, fetch_gnt}, 32'd0);
      chk("bp_ngrant", ngrant, 32'd2);
      chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_hold_data", rsp_instr, 32'h1111_1111);
      fetch_req = 1'b0; rsp_ready = 1'b1;
      cyc();
      chk("bp_drain1", rsp_instr, 32'h2222_2222);
      cyc();
      chk("bp_drained", {31'b0, rsp_valid}, 32'd0);

      // Error fetches and dropped writes.
      fetch1(32'h2);
      chk("mis_err",  {31'b0, rsp_err}, 32'd1);
      chk("mis_nop",  rsp_instr, 32'h0);
      cyc();
      fetch1(32'd4096);
      chk("oor_err",  {31'b0, rsp_err}, 32'd1);
      chk("oor_nop",  rsp_instr, 32'h0);
      cyc();
      wr(32'h2, 32'hFFFF_FFFF, 4'hF);
      wr(32'd4096, 32'hEEEE_EEEE, 4'hF);
      fetch1(32'h0);
      chk("badwr_data", rsp_instr, 32'h1111_1111);
      chk("badwr_err",  {31'b0, rsp_err}, 32'd0);
      cyc();

      // Flush with a surviving same-cycle request.
      rsp_ready = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0;
      cyc();
      fetch_addr = 32'h4;
      cyc();
      flush = 1'b1; fetch_addr = 32'h8; rsp_ready = 1'b1;
      #1 chk("fl_gnt", {31'b0, fetch_gnt}, 32'd1);
      chk("fl_head", rsp_instr, 32'h1111_1111);
      cyc();
      flush = 1'b0; fetch_req = 1'b0;
      chk("fl_valid", {31'b0, rsp_valid}, 32'd1);
      chk("fl_data",  rsp_instr, 32'hAABB_CC99);
      cyc();
      chk("fl_empty", {31'b0, rsp_valid}, 32'd0);
      // Credits back to zero: exactly two more grants with ready low.
      rsp_ready = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0;
      #1 chk("fl_cred0", {31'b0, fetch_gnt}, 32'd1);
      cyc();
      #1 chk("fl_cred1", {31'b0, fetch_gnt}, 32'd1);
      cyc();
      #1 chk("fl_cred2", {31'b0, fetch_gnt}, 32'd0);
      fetch_req = 1'b0; rsp_ready = 1'b1;
      cyc();
      cyc();
      chk("fl_cred_drain", {31'b0, rsp_valid}, 32'd0);

      // Write-first collisions.
      wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'h5; wr_be = 4'hF;
      fetch1(32'h10);
      wr_en = 1'b0;
      chk("col_full", rsp_instr, 32'h5);
      cyc();
      wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'h77; wr_be = 4'b0001;
      fetch1(32'h8);
      wr_en = 1'b0;
      chk("col_merge", rsp_instr, 32'hAABB_CC77);
      cyc();

      // Reset mid-burst.
      rsp_ready = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0;
      cyc();
      cyc();
      chk("rst_pre_valid", {31'b0, rsp_valid}, 32'd1);
      rst_n = 1'b0; fetch_req = 1'b0;
      #1 chk("rst_async_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_async_instr", rsp_instr, 32'h0);
      cyc();
      rst_n = 1'b1;
      cyc();
      fetch1(32'h4);
      chk("rst_keep4", rsp_instr, 32'h2222_2222);
      cyc();
      fetch1(32'h10);
      chk("rst_keep10", rsp_instr, 32'h5);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
